// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: shared sizes, subpacket type and the serial BCH update
// used by the data-island packet serializer.
package hdmi_packet_pkg;
   localparam int PACKET_WORDS = 32;
   localparam int HEADER_BITS = 24;
   localparam int SUB_BITS = 56;
   localparam int SUBPACKETS = 4;
   localparam logic [7:0] BCH_POLY_DEFAULT = 8'h83;

   typedef logic [SUB_BITS-1:0] subpacket_t;

   // LSB-first serial BCH step for G(x)=1+x^6+x^7+x^8
   function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b,
                                           input logic [7:0] poly = BCH_POLY_DEFAULT);
      return {1'b0, ecc[7:1]} ^ ((ecc[0] ^ b) ? poly : 8'h00);
   endfunction
endpackage

// File: rtl/bch_ecc_serial.sv
// bch_ecc_serial: serial BCH parity accumulator, BITS_PER_CYCLE bits per clock
// (bit 0 first); clear_i makes this cycle's update start from zero.
module bch_ecc_serial
   import hdmi_packet_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1,
   parameter logic [7:0] POLY = BCH_POLY_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic                      en_i,
   input  logic [BITS_PER_CYCLE-1:0] d_i,
   output logic [7:0]                ecc_o
);
   logic [7:0] ecc_q, ecc_d;

   always_comb begin
      ecc_d = clear_i ? 8'd0 : ecc_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++)
         ecc_d = en_i ? bch_step(ecc_d, d_i[i], POLY) : ecc_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) ecc_q <= 8'd0;
      else ecc_q <= ecc_d;

   assign ecc_o = ecc_q;
endmodule

// File: rtl/data_island_packet_serializer.sv
// data_island_packet_serializer: serializes header + four subpackets into the
// 32-word HDMI data-island body with BCH parity appended per channel.
module data_island_packet_serializer
   import hdmi_packet_pkg::*;
#(
   parameter logic [7:0] BCH_POLY = BCH_POLY_DEFAULT,
   parameter bit HOLD_INPUTS = 1'b1
) (
   input  logic                              clk_pixel,
   input  logic                              reset_n,
   input  logic                              data_island_period,
   input  logic [HEADER_BITS-1:0]            header,
   input  subpacket_t [SUBPACKETS-1:0]       sub,
   output logic [8:0]                        packet_data,
   output logic                              packet_start,
   output logic                              packet_end
);
   logic [4:0] c_q, c_d;
   logic [HEADER_BITS-1:0] hdr_q, hdr;
   subpacket_t [SUBPACKETS-1:0] sub_q, sb;
   logic [8:0] data_q, data_d;
   logic start_q, end_q, live, clr;
   logic [7:0] hecc;
   logic [SUBPACKETS-1:0][7:0] secc;

   // word 0 always comes straight from the inputs; later words from the shadow copy
   assign live = !HOLD_INPUTS || c_q == 5'd0;
   assign hdr = live ? header : hdr_q;
   assign sb = live ? sub : sub_q;
   assign clr = !data_island_period || c_q == 5'd0;
   assign c_d = data_island_period ? c_q + 5'd1 : 5'd0;

   bch_ecc_serial #(.BITS_PER_CYCLE(1), .POLY(BCH_POLY)) u_hecc (
      .clk_i(clk_pixel), .rst_ni(reset_n), .clear_i(clr),
      .en_i(data_island_period && c_q < 5'd24), .d_i(hdr[c_q]), .ecc_o(hecc)
   );

   for (genvar k = 0; k < SUBPACKETS; k++) begin : g_sub
      bch_ecc_serial #(.BITS_PER_CYCLE(2), .POLY(BCH_POLY)) u_secc (
         .clk_i(clk_pixel), .rst_ni(reset_n), .clear_i(clr),
         .en_i(data_island_period && c_q < 5'd28), .d_i(sb[k][{c_q, 1'b0} +: 2]),
         .ecc_o(secc[k])
      );
   end

   always_comb begin
      data_d[0] = c_q < 5'd24 ? hdr[c_q] : hecc[c_q[2:0]];
      for (int i = 0; i < SUBPACKETS; i++) begin
         data_d[1+i] = c_q < 5'd28 ? sb[i][{c_q, 1'b0}] : secc[i][{c_q[1:0], 1'b0}];
         data_d[5+i] = c_q < 5'd28 ? sb[i][{c_q, 1'b1}] : secc[i][{c_q[1:0], 1'b1}];
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n)
      if (!reset_n) begin
         c_q <= 5'd0;
         hdr_q <= '0;
         sub_q <= '0;
         data_q <= 9'd0;
         start_q <= 1'b0;
         end_q <= 1'b0;
      end else begin
         c_q <= c_d;
         data_q <= data_island_period ? data_d : 9'd0;
         start_q <= data_island_period && c_q == 5'd0;
         end_q <= data_island_period && c_q == 5'd31;
         if (data_island_period && c_q == 5'd0) begin
            hdr_q <= header;
            sub_q <= sub;
         end
      end

   assign packet_data = data_q;
   assign packet_start = start_q;
   assign packet_end = end_q;
endmodule

// File: tb/tb_data_island_packet_serializer.sv
// tb_data_island_packet_serializer: scoreboard bench; the driver pushes the
// expected word per cycle from a batch-parity model, a monitor pops and compares.
module tb_data_island_packet_serializer;
   import hdmi_packet_pkg::*;

   logic clk_pixel = 1'b0, reset_n = 1'b0, data_island_period = 1'b0;
   logic [23:0] header = '0;
   subpacket_t [3:0] sub = '0;
   logic [8:0] packet_data;
   logic packet_start, packet_end;
   int total = 0, bad = 0;

   typedef struct packed {logic [8:0] d; logic s; logic e;} exp_t;
   exp_t exp_q[$];
   logic [8:0] seen[$];
   logic [4:0] mc = '0;
   logic [23:0] mh;
   subpacket_t [3:0] ms;
   logic [7:0] mhe;
   logic [3:0][7:0] mse;

   data_island_packet_serializer dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .data_island_period(data_island_period),
      .header(header), .sub(sub), .packet_data(packet_data),
      .packet_start(packet_start), .packet_end(packet_end)
   );

   always #5 clk_pixel = ~clk_pixel;

   function automatic logic [7:0] par(input logic [63:0] v, input int n);
      logic [7:0] e = 8'd0;
      for (int i = 0; i < n; i++) e = {1'b0, e[7:1]} ^ ((e[0] ^ v[i]) ? 8'h83 : 8'h00);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic step(input logic dip);
      exp_t x;
      @(negedge clk_pixel);
      reset_n = 1'b1;
      data_island_period = dip;
      x = '0;
      if (dip) begin
         if (mc == 5'd0) begin
            mh = header;
            ms = sub;
            mhe = par({40'd0, mh}, 24);
            for (int k = 0; k < 4; k++) mse[k] = par({8'd0, ms[k]}, 56);
         end
         x.d[0] = mc < 24 ? mh[mc] : mhe[mc-24];
         for (int k = 0; k < 4; k++) begin
            x.d[1+k] = mc < 28 ? ms[k][2*mc] : mse[k][2*(mc-28)];
            x.d[5+k] = mc < 28 ? ms[k][2*mc+1] : mse[k][2*(mc-28)+1];
         end
         x.s = mc == 5'd0;
         x.e = mc == 5'd31;
         mc++;
      end else mc = 5'd0;
      exp_q.push_back(x);
   endtask

   task automatic rst_pulse();
      @(negedge clk_pixel);
      reset_n = 1'b0;
      #1;
      chk("async_rst", {packet_data, packet_start, packet_end}, 0);
      mc = 5'd0;
      exp_q.push_back('0);
   endtask

   task automatic sync();
      @(posedge clk_pixel);
      #2;
      seen.delete();
   endtask

   task automatic packet();
      sync();
      repeat (32) step(1'b1);
      step(1'b0);
      @(posedge clk_pixel);
      #2;
   endtask

   always @(posedge clk_pixel) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("word", {packet_data, packet_start, packet_end}, x);
         seen.push_back(packet_data);
      end
   end

   initial begin
      logic [8:0] acc;
      logic [7:0] p;
      #1;
      chk("reset", {packet_data, packet_start, packet_end}, 0);
      repeat (50) step(1'b0);

      packet();
      acc = '0;
      for (int i = 0; i < 32; i++) acc |= seen[i];
      chk("zero_pkt", acc, 0);

      header = 24'h000001;
      packet();
      chk("hdr_w0", seen[0][0], 1);
      acc = '0;
      for (int i = 1; i < 24; i++) acc[0] |= seen[i][0];
      chk("hdr_w1_23", acc[0], 0);
      for (int i = 0; i < 8; i++) p[i] = seen[24+i][0];
      chk("hdr_par", p, 8'h4A);

      header = '0;
      sub[2] = 56'h1;
      packet();
      chk("sub2_w0", seen[0], 9'b000001000);
      for (int j = 0; j < 4; j++) begin
         p[2*j] = seen[28+j][3];
         p[2*j+1] = seen[28+j][7];
      end
      chk("sub2_par", p, par(64'h1, 56));

      header = 24'h0D0282;
      sub[0] = 56'h0123456789ABCD;
      sub[1] = 56'hFEDCBA98765432;
      sub[2] = 56'h00FF00FF00FF00;
      sub[3] = 56'h5A5AA5A55A5AA5;
      sync();
      repeat (32) step(1'b1);
      repeat (10) step(1'b1);
      header = 24'h7FFFFF;
      sub[1] = 56'h0;
      sub[3] = 56'hFFFFFFFFFFFFFF;
      repeat (22) step(1'b1);
      step(1'b0);

      header = 24'h0D0282;
      repeat (10) step(1'b1);
      repeat (3) step(1'b0);
      repeat (32) step(1'b1);
      step(1'b0);

      repeat (17) step(1'b1);
      rst_pulse();
      repeat (32) step(1'b1);
      step(1'b0);

      repeat (2) @(posedge clk_pixel);
      #2;
      chk("drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_island_packet_serializer.md
Name: data_island_packet_serializer

Overview:
- Consumes one 24-bit packet header and four 56-bit subpackets, as produced by the InfoFrame and packet generators.
- Serializes them into the 32-cycle HDMI data-island packet body and appends BCH parity: BCH(32,24) on the header, BCH(64,56) on each subpacket.
- Output is a 9-bit word per pixel clock: bit 0 feeds TMDS channel 0 bit 2; bits [4:1] and [8:5] feed channels 1 and 2.
- Sits between the packet picker/generators and the TMERC4 data-island encoder.

Parameters:
- BCH_POLY, 8'h83, serial BCH feedback mask for G(x)=1+x^6+x^7+x^8, LSB-first update form.
- HOLD_INPUTS, 1, 1 = header/sub captured into shadow registers at word 0; 0 = inputs sampled live every cycle (upstream must hold them stable for 32 cycles).

Ports:
- clk_pixel  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_island_period  in  1  high for each cycle a packet word is to be emitted.
- header  in  24  packet header HB0..HB2, bit 0 transmitted first.
- sub  in  4x56  subpackets 0..3 (each PB0..PB6 + ...), bit 0 first.
- packet_data  out  9  registered serialized packet word.
- packet_start  out  1  registered pulse coincident with word 0.
- packet_end  out  1  registered pulse coincident with word 31; upstream advances to the next packet on it.

Behaviour:
- Reset (asynchronous, reset_n=0) clears:
  - counter, header ECC, all four sub ECC registers and all shadow registers → 0;
  - packet_data=9'd0, packet_start=0, packet_end=0.
- Word counter c, 5 bits:
  - clock edge with data_island_period=1: c increments and wraps 31→0, so back-to-back packets need no idle cycle;
  - clock edge with data_island_period=0: c=0, all ECC registers=0, packet_data=0, packet_start=0, packet_end=0.
- Capture (HOLD_INPUTS=1): on the edge with data_island_period=1 and c=0:
  - shadow registers load header and sub;
  - word 0 is built directly from the inputs;
  - words 1..31 are built from the shadow registers.
- Latency: word c appears on packet_data one clock after the edge at which the counter held c. First word appears one clock after data_island_period rises.
- Header channel, packet_data[0]:
  - c=0..23: header[c];
  - c=24..31: hecc[c-24], where hecc is the parity after all 24 header bits.
- Subpacket channels, k=0..3:
  - c=0..27: packet_data[1+k]=sub[k][2c] and packet_data[5+k]=sub[k][2c+1];
  - c=28..31: packet_data[1+k]=secc[k][2(c-28)] and packet_data[5+k]=secc[k][2(c-28)+1].
- ECC serial step for data bit b: e' = (e>>1) ^ ((e[0]^b) ? BCH_POLY : 0).
  - Header: one step per cycle for c=0..23.
  - Subpackets: two steps per cycle for c=0..27, even bit first.
  - Registers hold their value during the parity cycles.
  - Registers are cleared at each word 0 (the step from 0 is used for word 0) and on data_island_period=0.
- Output pulses: packet_start=1 exactly with word 0; packet_end=1 exactly with word 31; both 0 otherwise.
- Abort: if data_island_period falls mid-packet, the partial packet is discarded. No packet_end is issued and the next assertion restarts at word 0.
- Reset asserted mid-packet: same as abort, applied asynchronously.
- Input changes after capture (HOLD_INPUTS=1) have no effect until the next word 0.

Decomposition:
- Package hdmi_packet_pkg holds:
  - PACKET_WORDS=32, HEADER_BITS=24, SUB_BITS=56, SUBPACKETS=4, BCH_POLY_DEFAULT=8'h83;
  - typedef subpacket_t (logic [55:0]);
  - function bch_step(ecc, bit) returning the next ECC value.
- Sub-module bch_ecc_serial, parameter BITS_PER_CYCLE (1 or 2), with clear/enable/data inputs and an 8-bit ecc output. Instantiated once for the header and four times for the subpackets.

Test Plan:
- Idle: data_island_period=0 for 50 cycles → packet_data=0, packet_start=0, packet_end=0 throughout.
- All-zero packet, 32 cycles of data_island_period → 32 words of 9'd0, including parity; packet_start on word 0, packet_end on word 31.
- header=24'h000001, sub=0 → packet_data[0]=1 at word 0, 0 for words 1..23; header parity 8'h4A, so words 24..31 bit 0 = 0,1,0,1,0,0,1,0.
- sub[2]=56'h1, others 0 → word 0 packet_data=9'b000001000; sub[2] parity equals the software model of the two-bit-per-cycle update (checked against bch_step).
- Back-to-back AVI packets (header 24'h0D0282):
  - two packets with no gap → second word 0 is the cycle after the first word 31, with ECC restarted;
  - altering inputs mid-packet → no change in the current packet.
- Drop data_island_period at word 10, reassert → no packet_end, output 0 while low, next packet restarts cleanly at word 0. Repeat with reset_n pulsed low at word 17 → all outputs 0 immediately, without waiting for a clock edge.
